// File: rtl/vector_sequencer.sv
// vector_sequencer: self-running command issuer for the vector processor.
// Holds a small program of vector instructions and presents them one at a
// time on a ready/valid command port (opcode, rf_address, mem_address).
// Optional feature: define VSEQ_PERF_CNT_EN to build the saturating stall
// counter behind stall_cnt; without it stall_cnt is a constant zero.
module vector_sequencer #(
  parameter int PROG_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [9:0]         prog_wdata,
  input  logic               start,
  input  logic [PROG_AW-1:0] start_pc,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [1:0]         opcode,
  output logic [1:0]         rf_address,
  output logic [4:0]         mem_address,
  output logic               busy,
  output logic               done,
  output logic [PROG_AW-1:0] pc,
  output logic [15:0]        stall_cnt
);

  localparam int                 DEPTH   = 2**PROG_AW;
  localparam logic [PROG_AW-1:0] LAST_PC = {PROG_AW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

  state_t             r_state;
  // Command fields {opcode, rf_address, mem_address} live in the main store;
  // the halt bits sit in a small separate array so the fetch edge can decide
  // cmd_valid in the same cycle the command fields are read.
  logic [8:0]         r_mem  [DEPTH];
  logic               r_halt [DEPTH];
  logic [8:0]         r_cmd;
  logic               r_cmd_valid;
  logic               r_busy;
  logic               r_done;
  logic [PROG_AW-1:0] r_pc;
  logic               w_prog_en;

  // Program writes are only honoured while no program is running
  assign w_prog_en = prog_we && (r_state == S_IDLE || r_state == S_DONE);

  // Program store write port; not reset so the program survives rst_n
  always_ff @(posedge clk) begin
    if (w_prog_en) begin
      r_mem[prog_addr]  <= prog_wdata[8:0];
      r_halt[prog_addr] <= prog_wdata[9];
    end
  end

  // Sequencer FSM: fetch, offer the command until accepted, advance or finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pc        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= start_pc;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Registered read; a halt word never raises cmd_valid
          r_cmd       <= r_mem[r_pc];
          r_cmd_valid <= ~r_halt[r_pc];
          r_state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!r_cmd_valid) begin
            // Halt word fetched: finish without offering a command
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (r_pc == LAST_PC) begin
              // End of the store: stop rather than wrap to address 0
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef VSEQ_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles a command is offered but refused, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_ISSUE && r_cmd_valid && !cmd_ready &&
                 r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

  assign cmd_valid   = r_cmd_valid;
  assign opcode      = r_cmd[8:7];
  assign rf_address  = r_cmd[6:5];
  assign mem_address = r_cmd[4:0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign pc          = r_pc;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: expected commands are queued as
// each program is loaded and compared against the commands the DUT hands over.
module tb_vector_sequencer;

  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [9:0]    prog_wdata;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [1:0]    opcode;
  logic [1:0]    rf_address;
  logic [4:0]    mem_address;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [15:0]   stall_cnt;
  logic [8:0]    fields;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard and observations from the most recent run
  logic [8:0]    exp_q[$];
  logic [8:0]    obs_q[$];
  int            obs_cyc[$];
  int            n_done;
  logic [AW-1:0] done_pc;
  logic [15:0]   done_stall;
  int            busy_cycles;
  int            hold_cycles;
  bit            held_ok;
  bit            timed_out;

  vector_sequencer #(.PROG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .start_pc(start_pc),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .opcode(opcode),
    .rf_address(rf_address), .mem_address(mem_address), .busy(busy),
    .done(done), .pc(pc), .stall_cnt(stall_cnt)
  );

  assign fields = {opcode, rf_address, mem_address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] enc(input logic h, input logic [1:0] op,
                                     input logic [1:0] rf, input logic [4:0] ma);
    return {h, op, rf, ma};
  endfunction

  // {load r0 v0, load r1 v1, sum, store r2 v31, store r3 v30, halt}
  function automatic logic [9:0] prog_a(input int i);
    case (i)
      0:       return enc(1'b0, 2'd2, 2'd0, 5'd0);
      1:       return enc(1'b0, 2'd2, 2'd1, 5'd1);
      2:       return enc(1'b0, 2'd0, 2'd2, 5'd5);
      3:       return enc(1'b0, 2'd3, 2'd2, 5'd31);
      4:       return enc(1'b0, 2'd3, 2'd3, 5'd30);
      default: return enc(1'b1, 2'd0, 2'd0, 5'd0);
    endcase
  endfunction

  task automatic write_word(input logic [AW-1:0] a, input logic [9:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic push_exp_a();
    logic [9:0] w;
    for (int i = 0; i < 5; i++) begin
      w = prog_a(i);
      exp_q.push_back(w[8:0]);
    end
  endtask

  // Start a program and record what the DUT does until a few cycles past done.
  // Optionally refuses the command with index stall_idx for stall_len cycles,
  // and optionally pokes a RAM write plus a start while the first command is up.
  task automatic run_seq(input logic [AW-1:0] spc, input int stall_idx,
                         input int stall_len, input bit inject);
    int c, stalls, after;
    logic [8:0] held;
    obs_q.delete(); obs_cyc.delete();
    n_done = 0; done_pc = '0; done_stall = '0; busy_cycles = 0;
    hold_cycles = 0; held_ok = 1'b1; timed_out = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1; start_pc = spc; cmd_ready = 1'b1;
    c = 0; stalls = 0; after = -1;
    while (after != 0) begin
      @(negedge clk);
      c++;
      start = 1'b0; prog_we = 1'b0;
      if (inject && c == 2) begin
        prog_we = 1'b1; prog_addr = 4'd3; prog_wdata = 10'h155;
        start = 1'b1; start_pc = 4'd9;
      end
      if (busy) busy_cycles++;
      if (done) begin
        n_done++; done_pc = pc; done_stall = stall_cnt;
        if (after < 0) after = 4;
      end
      if (cmd_valid) begin
        if (obs_q.size() == stall_idx && stalls < stall_len) begin
          if (stalls == 0) held = fields;
          else if (fields !== held) held_ok = 1'b0;
          hold_cycles++; stalls++;
          cmd_ready = 1'b0;
        end else begin
          if (stalls > 0 && obs_q.size() == stall_idx) begin
            hold_cycles++;
            if (fields !== held) held_ok = 1'b0;
          end
          cmd_ready = 1'b1;
          obs_q.push_back(fields);
          obs_cyc.push_back(c);
        end
      end else begin
        cmd_ready = 1'b1;
      end
      if (after > 0) after--;
      if (c >= 100) begin timed_out = 1'b1; after = 0; end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %0b expected 0", cmd_valid); end
    n_checks++; if (fields !== 9'd0) begin n_fail++; $display("FAIL rst_fields: got %0h expected 0", fields); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
    n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL rst_pc: got %0d expected 0", pc); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
    $display("test_reset: outputs checked after reset release");
  endtask

  task automatic test_program();
    logic [8:0] e, o;
    for (int i = 0; i < 6; i++) write_word(i[AW-1:0], prog_a(i));
    push_exp_a();
    run_seq(4'd0, -1, 0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL prog_timeout: got timeout expected done"); end
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL prog_count: got %0d expected 5", obs_q.size()); end
    n_checks++; if (obs_cyc.size() > 0 && obs_cyc[0] !== 2) begin n_fail++; $display("FAIL prog_first_latency: got %0d expected 2", obs_cyc[0]); end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_checks++; if (obs_cyc[i] - obs_cyc[i-1] !== 2) begin n_fail++; $display("FAIL prog_spacing[%0d]: got %0d expected 2", i, obs_cyc[i] - obs_cyc[i-1]); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL prog_cmd: got %0h expected %0h", o, e); end
      $display("test_program: command %0h accepted", o);
    end
    exp_q.delete();
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL prog_done_count: got %0d expected 1", n_done); end
    n_checks++; if (done_pc !== 4'd5) begin n_fail++; $display("FAIL prog_done_pc: got %0d expected 5", done_pc); end
    n_checks++; if (done_stall !== 16'd0) begin n_fail++; $display("FAIL prog_stall_cnt: got %0d expected 0", done_stall); end
  endtask

  task automatic test_stall();
    logic [8:0] e, o;
    logic [15:0] exp_stall;
`ifdef VSEQ_PERF_CNT_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    push_exp_a();
    run_seq(4'd0, 2, 3, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout: got timeout expected done"); end
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", obs_q.size()); end
    n_checks++; if (hold_cycles !== 4) begin n_fail++; $display("FAIL stall_hold_cycles: got %0d expected 4", hold_cycles); end
    n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL stall_fields_stable: got %0b expected 1", held_ok); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL stall_cmd: got %0h expected %0h", o, e); end
      $display("test_stall: command %0h accepted", o);
    end
    exp_q.delete();
    n_checks++; if (done_stall !== exp_stall) begin n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", done_stall, exp_stall); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_no_wrap();
    logic [8:0] e, o;
    logic [9:0] w14, w15;
    w14 = enc(1'b0, 2'd1, 2'd1, 5'd7);
    w15 = enc(1'b0, 2'd3, 2'd0, 5'd16);
    write_word(4'd14, w14);
    write_word(4'd15, w15);
    exp_q.push_back(w14[8:0]);
    exp_q.push_back(w15[8:0]);
    run_seq(4'd14, -1, 0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL nowrap_timeout: got timeout expected done"); end
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL nowrap_count: got %0d expected 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL nowrap_cmd: got %0h expected %0h", o, e); end
      $display("test_no_wrap: command %0h accepted", o);
    end
    exp_q.delete();
    n_checks++; if (done_pc !== 4'd15) begin n_fail++; $display("FAIL nowrap_pc: got %0d expected 15", done_pc); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL nowrap_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_halt_first();
    write_word(4'd7, enc(1'b1, 2'd2, 2'd1, 5'd3));
    run_seq(4'd7, -1, 0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL halt_timeout: got timeout expected done"); end
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL halt_cmds: got %0d expected 0", obs_q.size()); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL halt_done_count: got %0d expected 1", n_done); end
    n_checks++; if (busy_cycles !== 2) begin n_fail++; $display("FAIL halt_busy_cycles: got %0d expected 2", busy_cycles); end
    n_checks++; if (done_pc !== 4'd7) begin n_fail++; $display("FAIL halt_pc: got %0d expected 7", done_pc); end
    $display("test_halt_first: done after %0d busy cycles", busy_cycles);
  endtask

  task automatic test_ignore_in_issue();
    logic [8:0] e, o;
    push_exp_a();
    run_seq(4'd0, -1, 0, 1'b1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL ignore_timeout: got timeout expected done"); end
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL ignore_count: got %0d expected 5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL ignore_cmd: got %0h expected %0h", o, e); end
      $display("test_ignore_in_issue: command %0h accepted", o);
    end
    exp_q.delete();
    n_checks++; if (done_pc !== 4'd5) begin n_fail++; $display("FAIL ignore_pc: got %0d expected 5", done_pc); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e, o;
    int n;
    bit hit;
    @(negedge clk);
    start = 1'b1; start_pc = 4'd0; cmd_ready = 1'b1;
    n = 0; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cmd_valid) begin
        n++;
        if (n == 3) begin cmd_ready = 1'b0; hit = 1'b1; end
      end
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: got %0b expected 1", hit); end
    n_checks++; if (pc !== 4'd2) begin n_fail++; $display("FAIL rstmid_pc_before: got %0d expected 2", pc); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_valid: got %0b expected 0", cmd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL rstmid_pc: got %0d expected 0", pc); end
    n_checks++; if (fields !== 9'd0) begin n_fail++; $display("FAIL rstmid_fields: got %0h expected 0", fields); end
    $display("test_reset_mid: reset applied during ISSUE");
    @(negedge clk);
    rst_n = 1'b1; cmd_ready = 1'b1;
    push_exp_a();
    run_seq(4'd0, -1, 0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL rstmid_timeout: got timeout expected done"); end
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_cmd: got %0h expected %0h", o, e); end
      $display("test_reset_mid: command %0h accepted", o);
    end
    exp_q.delete();
    n_checks++; if (done_pc !== 4'd5) begin n_fail++; $display("FAIL rstmid_done_pc: got %0d expected 5", done_pc); end
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; start_pc = '0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_program();
    test_stall();
    test_no_wrap();
    test_halt_first();
    test_ignore_in_issue();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Hardware command issuer for the vector processor: holds a small program of vector instructions (load / sum / multiply / store) and drives them onto the processor's opcode, register-file address and memory-address inputs, one command per handshake. It sits in front of the processor and replaces bench-driven command sequences with a self-running, ready/valid-controlled instruction stream.

## Interface
- PROG_AW, 4: program RAM address width; depth is 2**PROG_AW entries.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- prog_we  input  1  program write strobe.
- prog_addr  input  PROG_AW  program write address.
- prog_wdata  input  10  instruction word: [9] halt, [8:7] opcode, [6:5] rf_address, [4:0] mem_address.
- start  input  1  begin execution at start_pc; sampled only in IDLE.
- start_pc  input  PROG_AW  first instruction address.
- cmd_ready  input  1  processor accepts the current command.
- cmd_valid  output  1  opcode/rf_address/mem_address hold a command.
- opcode  output  2  0 sum, 1 multiply, 2 load, 3 store.
- rf_address  output  2  vector register index.
- mem_address  output  5  memory vector index (16 words per vector).
- busy  output  1  high in FETCH or ISSUE.
- done  output  1  one-cycle pulse on program completion.
- pc  output  PROG_AW  address of the instruction being fetched or issued.
- stall_cnt  output  16  cycles with cmd_valid=1 and cmd_ready=0 (see Configuration).

## Operation
- Program RAM: 2**PROG_AW x 10, synchronous write when prog_we=1 and state is IDLE or DONE; writes in FETCH/ISSUE are dropped. Synchronous read, 1-cycle latency. Contents are not reset.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: start=1 -> pc<=start_pc, go FETCH. Otherwise stay.
- FETCH: RAM read of pc; next state ISSUE.
- ISSUE: if fetched word has halt=1 -> go DONE without asserting cmd_valid. Else cmd_valid=1, command fields driven from the fetched word; on cmd_valid&cmd_ready: if pc==2**PROG_AW-1 go DONE (no wrap), else pc<=pc+1, go FETCH.
- DONE: done=1 for exactly one cycle; next state IDLE; pc holds the last address.
- Command fields are stable while cmd_valid=1 and cmd_ready=0; cmd_valid never drops before acceptance.
- start while busy or in DONE is ignored.
- cmd_ready outside ISSUE is ignored.
- Opcode meaning is passed through unchanged; the sequencer does not check hazards or operand legality.

## Timing
- Reset values: cmd_valid=0, opcode=0, rf_address=0, mem_address=0, busy=0, done=0, pc=0, stall_cnt=0, state IDLE.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; an in-flight command is abandoned; RAM contents retained.
- start at edge N -> FETCH during cycle N+1 -> cmd_valid high from edge N+1+1.
- Back-to-back with cmd_ready tied high: one command accepted every 2 cycles.
- Command fields and cmd_valid are registered outputs; no combinational path from cmd_ready to any output.
- Halt at first instruction: start at edge N -> done pulse in cycle after edge N+3, cmd_valid never asserted.

## Configuration
- VSEQ_PERF_CNT_EN defined: stall_cnt increments by 1 each cycle in ISSUE with cmd_valid=1 and cmd_ready=0; saturates at 16'hFFFF; cleared on start acceptance and on reset.
- Not defined: stall_cnt tied to 0; no counter register.

## Test plan
- Program {load r0 v0, load r1 v1, sum, store r2 v31, store r3 v30, halt} at 0..5, start_pc=0, cmd_ready=1 -> five commands opcode 2,2,0,3,3 with matching rf/mem addresses, 2 cycles apart; done pulse once; pc=5.
- Same program, cmd_ready low 3 cycles on the third command -> opcode 0 held stable 4 cycles, accepted once; with VSEQ_PERF_CNT_EN stall_cnt=3 at done, else 0.
- Program with no halt, start_pc=14 (PROG_AW=4) -> commands from addresses 14,15 only, then done; pc=15, no wrap to 0.
- Halt word at start_pc=7 -> no cmd_valid, done pulse, busy high 2 cycles.
- prog_we to address 3 during ISSUE -> RAM unchanged; start during ISSUE -> ignored, sequence unaffected.
- rst_n low during ISSUE with cmd_valid=1 -> cmd_valid, busy, pc to 0 immediately; after release, restart at start_pc=0 reproduces first scenario (RAM retained).
